// File: rtl/exec_pkg.sv
// rtl/exec_pkg.sv - shared opcode, state and helper definitions for the execute stage
package exec_pkg;

  localparam int OP_W = 4;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_SLT = 4'd5,
    OP_SLL = 4'd6,
    OP_SRL = 4'd7,
    OP_MUL = 4'd8
  } op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  // Codes above OP_MUL are reserved and raise err when accepted.
  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return op <= OP_MUL;
  endfunction

endpackage

// File: rtl/exec_unit_seq_multiplier.sv
// rtl/exec_unit_seq_multiplier.sv - iterative shift-add multiplier, one partial product per cycle
module seq_multiplier
  import exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;
  logic [CW-1:0]    cnt_q;
  logic             run_q;

  // Next accumulator value; on the last iteration it is already the full product,
  // so the owner can capture it on the same edge that done is seen.
  always_comb begin
    acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  assign done    = run_q && (cnt_q == CW'(WIDTH - 1));
  assign product = acc_d;

  // Load operands on start, then shift multiplicand left and multiplier right each cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else if (start) begin
      mcand_q  <= a;
      mplier_q <= b;
      acc_q    <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b1;
    end else if (run_q) begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + 1'b1;
      if (done) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/exec_unit.sv
// rtl/exec_unit.sv - execute stage: single-cycle ALU, sequential multiply, register-file writeback
module exec_unit
  import exec_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AW    = 5,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] rd1,
  input  logic [WIDTH-1:0] rd2,
  input  logic [AW-1:0]    dst,
  output logic             wb_en,
  output logic [AW-1:0]    wb_addr,
  output logic [WIDTH-1:0] wb_data,
  output logic             busy,
  output logic             err
);

  state_e           state_q;
  logic             in_ready_q;
  logic             busy_q;
  logic             err_q;
  logic             wb_en_q;
  logic [AW-1:0]    wb_addr_q;
  logic [WIDTH-1:0] wb_data_q;
  logic [AW-1:0]    mul_dst_q;

  logic             accept;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH-1:0] alu_result;

  // in_ready is only high in S_IDLE, so an accept always happens from idle.
  assign accept    = in_valid && in_ready_q;
  assign mul_start = accept && (op == OP_MUL);

  // Single-cycle result for every non-multiply opcode.
  always_comb begin
    alu_result = '0;
    case (op)
      OP_ADD:  alu_result = rd1 + rd2;
      OP_SUB:  alu_result = rd1 - rd2;
      OP_AND:  alu_result = rd1 & rd2;
      OP_OR:   alu_result = rd1 | rd2;
      OP_XOR:  alu_result = rd1 ^ rd2;
      OP_SLT:  alu_result = {{(WIDTH-1){1'b0}}, ($signed(rd1) < $signed(rd2))};
      OP_SLL:  alu_result = rd1 << rd2[SHW-1:0];
      OP_SRL:  alu_result = rd1 >> rd2[SHW-1:0];
      default: alu_result = '0;
    endcase
  end

  seq_multiplier #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start),
    .a      (rd1),
    .b      (rd2),
    .done   (mul_done),
    .product(mul_product)
  );

  // Control FSM with registered handshake, status and writeback outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      in_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      wb_en_q    <= 1'b0;
      wb_addr_q  <= '0;
      wb_data_q  <= '0;
      mul_dst_q  <= '0;
    end else begin
      wb_en_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            if (op == OP_MUL) begin
              mul_dst_q  <= dst;
              state_q    <= S_MUL;
              busy_q     <= 1'b1;
              in_ready_q <= 1'b0;
            end else if (op_legal(op)) begin
              wb_en_q   <= 1'b1;
              wb_addr_q <= dst;
              wb_data_q <= alu_result;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_MUL: begin
          if (mul_done) begin
            wb_en_q    <= 1'b1;
            wb_addr_q  <= mul_dst_q;
            wb_data_q  <= mul_product;
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;
  assign err      = err_q;
  assign wb_en    = wb_en_q;
  assign wb_addr  = wb_addr_q;
  assign wb_data  = wb_data_q;

endmodule

// File: tb/tb_exec_unit.sv
// tb/tb_exec_unit.sv - self-checking bench for exec_unit against an arithmetic reference model
module tb_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic [4:0]  dst;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        busy;
  logic        err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  exec_unit #(.WIDTH(32), .AW(5), .SHW(5)) dut (
    .clk     (clk),
    .rst     (rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .op      (op),
    .rd1     (rd1),
    .rd2     (rd2),
    .dst     (dst),
    .wb_en   (wb_en),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .busy    (busy),
    .err     (err)
  );

  function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    case (o)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: return a << b[4:0];
      4'd7: return a >> b[4:0];
      4'd8: begin
        p = 64'(a) * 64'(b);
        return p[31:0];
      end
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
    in_valid = 1'b1;
    op       = o;
    rd1      = a;
    rd2      = b;
    dst      = d;
  endtask

  task automatic scramble_inputs();
    in_valid = 1'b0;
    op       = 4'($urandom);
    rd1      = $urandom;
    rd2      = $urandom;
    dst      = 5'($urandom);
  endtask

  // Called at a negedge; accepts on the next posedge and checks the one-cycle writeback and hold.
  task automatic alu_op(input string tag, input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] d);
    logic [31:0] exp;
    exp = model(o, a, b);
    present(o, a, b, d);
    @(posedge clk);
    @(negedge clk);
    scramble_inputs();
    check({tag, "_en"},   32'(wb_en), 32'd1);
    check({tag, "_addr"}, 32'(wb_addr), 32'(d));
    check({tag, "_data"}, wb_data, exp);
    check({tag, "_err"},  32'(err), 32'd0);
    @(negedge clk);
    check({tag, "_en_off"},    32'(wb_en), 32'd0);
    check({tag, "_addr_hold"}, 32'(wb_addr), 32'(d));
    check({tag, "_data_hold"}, wb_data, exp);
  endtask

  // Multiply with optional ADD held on in_valid through the whole multiply.
  task automatic mul_op(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [4:0] d,
                        input bit hold_add, input logic [31:0] x, input logic [31:0] y, input logic [4:0] hd);
    present(4'd8, a, b, d);
    @(posedge clk);
    @(negedge clk);
    if (hold_add) present(4'd0, x, y, hd);
    else scramble_inputs();
    for (int i = 0; i < 32; i++) begin
      check({tag, "_busy"},  32'(busy), 32'd1);
      check({tag, "_ready"}, 32'(in_ready), 32'd0);
      check({tag, "_noen"},  32'(wb_en), 32'd0);
      @(negedge clk);
    end
    check({tag, "_en"},       32'(wb_en), 32'd1);
    check({tag, "_addr"},     32'(wb_addr), 32'(d));
    check({tag, "_data"},     wb_data, model(4'd8, a, b));
    check({tag, "_idle"},     32'(busy), 32'd0);
    check({tag, "_ready_up"}, 32'(in_ready), 32'd1);
    if (hold_add) begin
      @(negedge clk);
      scramble_inputs();
      check({tag, "_add_en"},   32'(wb_en), 32'd1);
      check({tag, "_add_addr"}, 32'(wb_addr), 32'(hd));
      check({tag, "_add_data"}, wb_data, x + y);
    end
    @(negedge clk);
    check({tag, "_en_off"}, 32'(wb_en), 32'd0);
  endtask

  task automatic illegal_op(input string tag, input logic [3:0] o);
    present(o, $urandom, $urandom, 5'($urandom));
    @(posedge clk);
    @(negedge clk);
    scramble_inputs();
    check({tag, "_err"},   32'(err), 32'd1);
    check({tag, "_noen"},  32'(wb_en), 32'd0);
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    check({tag, "_err_off"}, 32'(err), 32'd0);
    check({tag, "_noen2"},   32'(wb_en), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    rst      = 1'b0;
    in_valid = 1'b0;
    op       = 4'd0;
    rd1      = '0;
    rd2      = '0;
    dst      = '0;

    repeat (2) begin
      @(negedge clk);
      check("rst_wb_en",    32'(wb_en), 32'd0);
      check("rst_wb_addr",  32'(wb_addr), 32'd0);
      check("rst_wb_data",  wb_data, 32'd0);
      check("rst_busy",     32'(busy), 32'd0);
      check("rst_err",      32'(err), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
    end
    rst = 1'b1;
    @(negedge clk);

    // Back-to-back ADD then SUB.
    present(4'd0, 32'hFFFF_FFFF, 32'd1, 5'd1);
    @(posedge clk);
    @(negedge clk);
    present(4'd1, 32'd3, 32'd5, 5'd2);
    check("b2b_add_en",   32'(wb_en), 32'd1);
    check("b2b_add_addr", 32'(wb_addr), 32'd1);
    check("b2b_add_data", wb_data, 32'h0);
    @(posedge clk);
    @(negedge clk);
    scramble_inputs();
    check("b2b_sub_en",   32'(wb_en), 32'd1);
    check("b2b_sub_addr", 32'(wb_addr), 32'd2);
    check("b2b_sub_data", wb_data, 32'hFFFF_FFFE);
    @(negedge clk);
    check("b2b_en_off", 32'(wb_en), 32'd0);

    // Directed logic and shift cases.
    alu_op("slt", 4'd5, 32'hFFFF_FFFF, 32'd1, 5'd5);
    check("slt_value", wb_data, 32'd1);
    alu_op("sll", 4'd6, 32'h1, 32'h24, 5'd6);
    check("sll_value", wb_data, 32'h10);
    alu_op("srl", 4'd7, 32'h8000_0000, 32'd31, 5'd7);
    check("srl_value", wb_data, 32'h1);
    alu_op("xor", 4'd4, 32'hF0F0, 32'hFF00, 5'd8);
    check("xor_value", wb_data, 32'h0FF0);

    // Multiplies, including the all-ones wrap and the stall/follow-on case.
    mul_op("mul76", 32'd7, 32'd6, 5'd3, 1'b0, 32'd0, 32'd0, 5'd0);
    check("mul76_value", wb_data, 32'd42);
    mul_op("mulff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 1'b0, 32'd0, 32'd0, 5'd0);
    check("mulff_value", wb_data, 32'h1);
    mul_op("mulstall", 32'd12345, 32'd678, 5'd10, 1'b1, 32'd100, 32'd23, 5'd11);

    // Illegal opcode.
    illegal_op("ill12", 4'd12);

    // Randomized traffic against the model.
    repeat (24) begin
      alu_op("rnd_alu", 4'($urandom_range(0, 7)), $urandom, $urandom, 5'($urandom));
    end
    repeat (3) begin
      a = $urandom;
      b = $urandom;
      mul_op("rnd_mul", a, b, 5'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom));
    end
    repeat (3) begin
      illegal_op("rnd_ill", 4'($urandom_range(9, 15)));
    end

    // Reset in the middle of a multiply: no writeback may ever appear.
    present(4'd8, 32'd7, 32'd9, 5'd4);
    @(posedge clk);
    @(negedge clk);
    scramble_inputs();
    repeat (9) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_busy",  32'(busy), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd1);
    check("midrst_en",    32'(wb_en), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("midrst_no_wb", 32'(wb_en), 32'd0);
      check("midrst_idle",  32'(busy), 32'd0);
    end

    // Unit still operational after reset.
    alu_op("post_rst_add", 4'd0, 32'd40, 32'd2, 5'd12);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
